// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the responder state encoding, word width, default geometry and the
// address legality check used by both the FSM and the storage array.
package dmem_pkg;

    localparam int unsigned WORD_W          = 32;
    localparam int unsigned DEPTH_DEFAULT   = 256;
    localparam int unsigned LATENCY_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Word-aligned and inside the array. The limit is computed two bits wider
    // than the address so that 4*DEPTH cannot wrap for large arrays.
    function automatic logic addr_legal(input logic [WORD_W-1:0] addr,
                                        input int unsigned       depth);
        logic [WORD_W+1:0] limit;
        limit = (WORD_W + 2)'(depth) << 2;
        return (addr[1:0] == 2'b00) && ({2'b00, addr} < limit);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 storage for the data-memory responder.
// Ports:
//   clk_i    clock
//   rst_i    async active-high reset (read register only; contents are not reset)
//   en_i     access strobe, high only on the edge that completes an access
//   we_i     1 = store, 0 = load
//   legal_i  access is legal; illegal accesses never write and read back 0
//   idx_i    word index
//   wdata_i  store data
//   rdata_o  registered load data, held between accesses
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic              legal_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i && legal_i && we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // Stores leave the read register untouched so the last load data holds.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (en_i) begin
            if (!legal_i) begin
                rdata_q <= '0;
            end else if (!we_i) begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the CPU MEM stage.
// Accepts one level-held request at a time, completes it LATENCY cycles later
// with a one-cycle ack, and stalls the pipeline until then.
// Ports:
//   clk_i, rst_i     clock, async active-high reset
//   req_i            request valid, held until ack_o
//   we_i             1 = store, 0 = load
//   addr_i           byte address
//   wdata_i          store data
//   ack_o            one-cycle completion pulse
//   rdata_o          load data, valid with ack_o, held until the next ack
//   err_o            access was misaligned or out of range (with ack_o)
//   stall_o          combinational pipeline hold
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = DEPTH_DEFAULT,
    parameter int unsigned LATENCY = LATENCY_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        stall_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              ack_q;
    logic              err_q;

    logic              access_en;
    logic              acc_we;
    logic [WORD_W-1:0] acc_addr;
    logic [WORD_W-1:0] acc_wdata;
    logic              acc_legal;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The access happens on the edge entering RESP. With LATENCY=1 that edge
    // is the acceptance edge, so the live inputs are used instead of the
    // latched copies. Reset gates the strobe because the array has no reset.
    assign access_en = !rst_i && (state_d == ST_RESP);
    assign acc_we    = (state_q == ST_IDLE) ? we_i    : we_q;
    assign acc_addr  = (state_q == ST_IDLE) ? addr_i  : addr_q;
    assign acc_wdata = (state_q == ST_IDLE) ? wdata_i : wdata_q;
    assign acc_legal = addr_legal(acc_addr, DEPTH);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= access_en;
            err_q   <= access_en && !acc_legal;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (access_en),
        .we_i    (acc_we),
        .legal_i (acc_legal),
        .idx_i   (acc_addr[IDX_W+1:2]),
        .wdata_i (acc_wdata),
        .rdata_o (rdata_o)
    );

    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign stall_o = ((state_q == ST_IDLE) && req_i) || (state_q == ST_BUSY);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a default instance (DEPTH 256, LATENCY 4)
// and a LATENCY 1 instance (DEPTH 16) share the request inputs.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack0, err0, stall0;
    logic [31:0] rdata0;
    logic        ack1, err1, stall1;
    logic [31:0] rdata1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(256), .LATENCY(4)) dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .ack_o(ack0), .rdata_o(rdata0), .err_o(err0), .stall_o(stall0)
    );

    dmem_responder #(.DEPTH(16), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .ack_o(ack1), .rdata_o(rdata1), .err_o(err1), .stall_o(stall1)
    );

    // Drives one access on the selected instance and reports when ack arrived
    // (cycle relative to acceptance, -1 on timeout), which cycles stalled,
    // and the data/err seen in the ack cycle.
    task automatic access(input bit sel, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output int ack_cyc,
                          output logic [31:0] mask, output logic [31:0] rd,
                          output logic er);
        ack_cyc = -1;
        mask    = '0;
        rd      = '0;
        er      = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        req = 1'b1; we = w; addr = a; wdata = d;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (sel ? stall1 : stall0) mask[c] = 1'b1;
            if (sel ? ack1 : ack0) begin
                ack_cyc = c;
                rd      = sel ? rdata1 : rdata0;
                er      = sel ? err1 : err0;
                req     = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
        req = 1'b0;
    endtask

    task automatic test_reset();
        int          ac;
        logic [31:0] m, rd;
        logic        er;
        #1;
        n_cmp++; if (ack0 !== 1'b0) begin n_bad++; $display("FAIL rst_ack: got %b exp 0", ack0); end
        n_cmp++; if (err0 !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b exp 0", err0); end
        n_cmp++; if (rdata0 !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h exp 0", rdata0); end
        n_cmp++; if (stall0 !== 1'b0) begin n_bad++; $display("FAIL rst_stall_lo: got %b exp 0", stall0); end
        req = 1'b1;
        #1;
        n_cmp++; if (stall0 !== 1'b1) begin n_bad++; $display("FAIL rst_stall_hi: got %b exp 1", stall0); end
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        access(1'b0, 1'b0, 32'h0, 32'h0, ac, m, rd, er);
        n_cmp++; if (rd !== 32'h11223344) begin n_bad++; $display("FAIL rst_pre_load: got %h exp 11223344", rd); end
        // Asynchronous reset mid-cycle while rdata holds a nonzero value.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_cmp++; if (rdata0 !== 32'h0) begin n_bad++; $display("FAIL async_rdata: got %h exp 0", rdata0); end
        n_cmp++; if (ack0 !== 1'b0) begin n_bad++; $display("FAIL async_ack: got %b exp 0", ack0); end
        #1;
        rst = 1'b0;
        access(1'b0, 1'b0, 32'h0, 32'h0, ac, m, rd, er);
        n_cmp++; if (ac !== 4) begin n_bad++; $display("FAIL post_rst_lat: got %0d exp 4", ac); end
        n_cmp++; if (rd !== 32'h11223344) begin n_bad++; $display("FAIL post_rst_load: got %h exp 11223344", rd); end
    endtask

    task automatic test_store_load();
        int          ac;
        logic [31:0] m, rd;
        logic        er;
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, ac, m, rd, er);
        n_cmp++; if (ac !== 4) begin n_bad++; $display("FAIL st_lat: got %0d exp 4", ac); end
        n_cmp++; if (m !== 32'h0000000F) begin n_bad++; $display("FAIL st_stall: got %h exp 0000000f", m); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL st_err: got %b exp 0", er); end
        access(1'b0, 1'b0, 32'h10, 32'h0, ac, m, rd, er);
        n_cmp++; if (ac !== 4) begin n_bad++; $display("FAIL ld_lat: got %0d exp 4", ac); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ld_rdata: got %h exp deadbeef", rd); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL ld_err: got %b exp 0", er); end
        access(1'b0, 1'b0, 32'h3FC, 32'h0, ac, m, rd, er);
        n_cmp++; if (rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL ld_last: got %h exp cafef00d", rd); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL ld_last_err: got %b exp 0", er); end
    endtask

    task automatic test_illegal();
        int          ac;
        logic [31:0] m, rd;
        logic        er;
        access(1'b0, 1'b1, 32'h12, 32'h0BAD0BAD, ac, m, rd, er);
        n_cmp++; if (ac !== 4) begin n_bad++; $display("FAIL mis_lat: got %0d exp 4", ac); end
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL mis_err: got %b exp 1", er); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mis_rdata: got %h exp 0", rd); end
        access(1'b0, 1'b0, 32'h10, 32'h0, ac, m, rd, er);
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL mis_nowrite: got %h exp deadbeef", rd); end
        access(1'b0, 1'b0, 32'h400, 32'h0, ac, m, rd, er);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL oob_err: got %b exp 1", er); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL oob_rdata: got %h exp 0", rd); end
    endtask

    task automatic test_latency1();
        int          ac;
        logic [31:0] m, rd;
        logic        er;
        access(1'b1, 1'b0, 32'h8, 32'h0, ac, m, rd, er);
        n_cmp++; if (ac !== 1) begin n_bad++; $display("FAIL l1_lat: got %0d exp 1", ac); end
        n_cmp++; if (m !== 32'h00000001) begin n_bad++; $display("FAIL l1_stall: got %h exp 00000001", m); end
        n_cmp++; if (rd !== 32'h55AA55AA) begin n_bad++; $display("FAIL l1_rdata: got %h exp 55aa55aa", rd); end
        access(1'b1, 1'b0, 32'h40, 32'h0, ac, m, rd, er);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL l1_oob_err: got %b exp 1", er); end
    endtask

    task automatic test_mid_op();
        int          ac;
        logic [31:0] m, rd;
        logic        er;
        ac = -1;
        rd = '0;
        repeat (6) @(posedge clk);
        #1;
        req = 1'b1; we = 1'b0; addr = 32'h10; wdata = 32'h0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (c == 1) begin
                n_cmp++; if (stall0 !== 1'b1) begin n_bad++; $display("FAIL busy_stall: got %b exp 1", stall0); end
                req = 1'b0; we = 1'b1; addr = 32'h20; wdata = 32'hFFFFFFFF;
            end
            if (ack0) begin
                ac = c;
                rd = rdata0;
                break;
            end
            @(posedge clk);
            #1;
        end
        req = 1'b0;
        n_cmp++; if (ac !== 4) begin n_bad++; $display("FAIL drop_lat: got %0d exp 4", ac); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL drop_rdata: got %h exp deadbeef", rd); end
        access(1'b0, 1'b0, 32'h20, 32'h0, ac, m, rd, er);
        n_cmp++; if (rd !== 32'h0BADCAFE) begin n_bad++; $display("FAIL drop_nowrite: got %h exp 0badcafe", rd); end
    endtask

    task automatic test_reset_busy();
        int          ac;
        logic [31:0] m, rd;
        logic        er;
        repeat (6) @(posedge clk);
        #1;
        req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'hA5A5A5A5;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_cmp++; if (dut0.state_q !== ST_IDLE) begin n_bad++; $display("FAIL rb_state: got %0d exp %0d", dut0.state_q, ST_IDLE); end
        n_cmp++; if (stall0 !== 1'b1) begin n_bad++; $display("FAIL rb_stall: got %b exp 1", stall0); end
        n_cmp++; if (ack0 !== 1'b0) begin n_bad++; $display("FAIL rb_ack: got %b exp 0", ack0); end
        req = 1'b0;
        #1;
        rst = 1'b0;
        access(1'b0, 1'b0, 32'h30, 32'h0, ac, m, rd, er);
        n_cmp++; if (rd !== 32'h12345678) begin n_bad++; $display("FAIL rb_nowrite: got %h exp 12345678", rd); end
        access(1'b0, 1'b0, 32'h10, 32'h0, ac, m, rd, er);
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rb_keep: got %h exp deadbeef", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [3];
        logic [31:0] exp_d [3];
        int          cyc [3];
        logic [31:0] dat [3];
        int          k;
        a[0] = 32'h0;   exp_d[0] = 32'h11223344;
        a[1] = 32'h10;  exp_d[1] = 32'hDEADBEEF;
        a[2] = 32'h3FC; exp_d[2] = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) begin cyc[i] = -1; dat[i] = '0; end
        k = 0;
        repeat (6) @(posedge clk);
        #1;
        req = 1'b1; we = 1'b0; addr = a[0];
        for (int c = 0; c < 20; c++) begin
            #1;
            if (ack0) begin
                cyc[k] = c;
                dat[k] = rdata0;
                k++;
                if (k == 3) break;
                addr = a[k];
            end
            @(posedge clk);
            #1;
        end
        req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (cyc[i] !== 4 + 5 * i) begin n_bad++; $display("FAIL b2b_cyc%0d: got %0d exp %0d", i, cyc[i], 4 + 5 * i); end
            n_cmp++; if (dat[i] !== exp_d[i]) begin n_bad++; $display("FAIL b2b_data%0d: got %h exp %h", i, dat[i], exp_d[i]); end
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        dut0.u_array.mem_q[0]   = 32'h11223344;
        dut0.u_array.mem_q[4]   = 32'h01020304;
        dut0.u_array.mem_q[8]   = 32'h0BADCAFE;
        dut0.u_array.mem_q[12]  = 32'h12345678;
        dut0.u_array.mem_q[255] = 32'hCAFEF00D;
        dut1.u_array.mem_q[2]   = 32'h55AA55AA;
        test_reset();
        test_store_load();
        test_illegal();
        test_latency1();
        test_mid_op();
        test_reset_busy();
        test_back_to_back();
        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
